// File: rtl/cache_miss_arbiter.sv
// Arbitrates I-cache misses, D-cache misses and D write-through stores onto the single memory4c port.
// Define MISS_ARB_PERF_CNT_EN to add the saturating per-cache fill counters i_fill_cnt / d_fill_cnt.
module cache_miss_arbiter #(
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned WORDS_PER_BLK = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_miss,
   input  logic [ADDR_W-1:0]                i_miss_addr,
   input  logic                             d_miss,
   input  logic [ADDR_W-1:0]                d_miss_addr,
   input  logic                             d_wr_req,
   input  logic [ADDR_W-1:0]                d_wr_addr,
   input  logic [DATA_W-1:0]                d_wr_data,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic [DATA_W-1:0]                mem_data_in,
   output logic                             mem_en,
   output logic                             mem_wr,
   input  logic [DATA_W-1:0]                mem_data_out,
   input  logic                             mem_data_valid,
   output logic [DATA_W-1:0]                fill_data,
   output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
   output logic                             i_data_we,
   output logic                             i_tag_we,
   output logic                             d_data_we,
   output logic                             d_tag_we,
   output logic                             i_stall,
   output logic                             d_stall,
   output logic                             busy
`ifdef MISS_ARB_PERF_CNT_EN
  ,output logic [15:0]                      i_fill_cnt,
   output logic [15:0]                      d_fill_cnt
`endif
);

   localparam int unsigned IDX_W  = $clog2(WORDS_PER_BLK);
   localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
   localparam int unsigned OFF_W  = IDX_W + BYTE_W;
   localparam logic [IDX_W:0]   BLK_WORDS = WORDS_PER_BLK[IDX_W:0];
   localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_BLK - 1);

   typedef enum logic       {ST_IDLE, ST_FILL}        state_e;
   typedef enum logic [1:0] {GR_NONE, GR_I, GR_D}     grant_e;

   state_e            state_q, state_d;
   grant_e            grant_q, grant_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [IDX_W:0]    issue_q, issue_d;
   logic [IDX_W-1:0]  recv_q, recv_d;

   logic              mem_en_c, mem_wr_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_data_in_c;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      base_d        = base_q;
      issue_d       = issue_q;
      recv_d        = recv_q;
      mem_en_c      = 1'b0;
      mem_wr_c      = 1'b0;
      mem_addr_c    = '0;
      mem_data_in_c = '0;
      i_data_we     = 1'b0;
      d_data_we     = 1'b0;
      i_tag_we      = 1'b0;
      d_tag_we      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (d_miss) begin
               grant_d = GR_D;
               base_d  = {d_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               state_d = ST_FILL;
            end else if (d_wr_req) begin
               mem_en_c      = 1'b1;
               mem_wr_c      = 1'b1;
               mem_addr_c    = d_wr_addr;
               mem_data_in_c = d_wr_data;
            end else if (i_miss) begin
               grant_d = GR_I;
               base_d  = {i_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            // Read issue and data return run independently; memory latency separates them.
            if (issue_q < BLK_WORDS) begin
               mem_en_c   = 1'b1;
               mem_addr_c = base_q | (ADDR_W'(issue_q[IDX_W-1:0]) << BYTE_W);
               issue_d    = issue_q + 1'b1;
            end
            if (mem_data_valid) begin
               i_data_we = (grant_q == GR_I);
               d_data_we = (grant_q == GR_D);
               recv_d    = recv_q + 1'b1;
               if (recv_q == LAST_WORD) begin
                  i_tag_we = (grant_q == GR_I);
                  d_tag_we = (grant_q == GR_D);
                  state_d  = ST_IDLE;
                  grant_d  = GR_NONE;
                  issue_d  = '0;
                  recv_d   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= GR_NONE;
         base_q  <= '0;
         issue_q <= '0;
         recv_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         base_q  <= base_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
      end
   end

   // The store path and stalls follow inputs combinationally, so rst_n masks them to hold every output at 0.
   assign busy        = (state_q == ST_FILL);
   assign mem_en      = rst_n & mem_en_c;
   assign mem_wr      = rst_n & mem_wr_c;
   assign mem_addr    = rst_n ? mem_addr_c : '0;
   assign mem_data_in = rst_n ? mem_data_in_c : '0;
   assign fill_data   = (rst_n && busy) ? mem_data_out : '0;
   assign fill_word   = recv_q;
   assign i_stall     = rst_n & (i_miss | (busy & (grant_q == GR_I)));
   assign d_stall     = rst_n & (d_miss | (busy & (grant_q == GR_D)) | (d_wr_req & (busy | d_miss)));

`ifdef MISS_ARB_PERF_CNT_EN
   logic [15:0] i_fill_cnt_q, d_fill_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_fill_cnt_q <= '0;
         d_fill_cnt_q <= '0;
      end else begin
         if (i_tag_we && (i_fill_cnt_q != '1)) i_fill_cnt_q <= i_fill_cnt_q + 16'd1;
         if (d_tag_we && (d_fill_cnt_q != '1)) d_fill_cnt_q <= d_fill_cnt_q + 16'd1;
      end
   end

   assign i_fill_cnt = i_fill_cnt_q;
   assign d_fill_cnt = d_fill_cnt_q;
`endif

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Scoreboard bench for cache_miss_arbiter: transaction-level model predicts memory traffic, fills and stalls.
module tb_cache_miss_arbiter;
   localparam int WORDS    = 8;
   localparam int LAT      = 4;
   localparam int FILL_CYC = WORDS + LAT;

   typedef struct {
      int          cyc;
      int          side;
      logic [15:0] a;
      logic [15:0] d;
   } ev_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
   logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
   logic [15:0] mem_data_out = '0;
   logic        mem_data_valid = 1'b0;
   logic [15:0] mem_addr, mem_data_in, fill_data;
   logic        mem_en, mem_wr, i_data_we, i_tag_we, d_data_we, d_tag_we, i_stall, d_stall, busy;
   logic [2:0]  fill_word;
`ifdef MISS_ARB_PERF_CNT_EN
   logic [15:0] i_fill_cnt, d_fill_cnt;
`endif

   always #5 clk = ~clk;

   cache_miss_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_data_we(i_data_we), .i_tag_we(i_tag_we), .d_data_we(d_data_we), .d_tag_we(d_tag_we),
      .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
`ifdef MISS_ARB_PERF_CNT_EN
     ,.i_fill_cnt(i_fill_cnt), .d_fill_cnt(d_fill_cnt)
`endif
   );

   int   checks = 0, failures = 0, cyc = 0;
   ev_t  rdq[$], wrq[$], dq[$], tq[$];
   int   st[3], done_cyc[3], n_fills[3];
   bit   freed[3];
   int   m_gr = 0, m_t0 = 0;
   bit   m_busy, exp_busy, exp_is, exp_ds;
   bit   started = 0, w_acc = 0, rand_drop = 0;
   bit   pv[4];
   logic [15:0] pa[4];
   bit   cap_v = 0;
   logic [15:0] cap_a = '0;
   ev_t  mon_e;
   int   mon_sd;

   function automatic logic [15:0] memval(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic fail_ev(input string name, input logic [63:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%h required=none cyc=%0d", name, act, cyc);
   endtask

   task automatic set_miss(input int s, input logic v);
      if (s == 1) i_miss = v; else d_miss = v;
   endtask

   task automatic grant(input int s, input logic [15:0] addr);
      logic [15:0] base;
      logic [15:0] a;
      ev_t e;
      base = {addr[15:4], 4'h0};
      m_gr = s; m_t0 = cyc; st[s] = 2; done_cyc[s] = cyc + FILL_CYC + 1; n_fills[s]++;
      for (int k = 0; k < WORDS; k++) begin
         a = base + 16'(2 * k);
         e.cyc = cyc + 1 + k; e.side = s; e.a = a; e.d = 16'h0;
         rdq.push_back(e);
         e.cyc = cyc + 1 + LAT + k; e.a = 16'(k); e.d = memval(a);
         dq.push_back(e);
      end
      e.cyc = cyc + FILL_CYC; e.side = s; e.a = 16'h0; e.d = 16'h0;
      tq.push_back(e);
   endtask

   task automatic begin_cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         rst_n = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
      end
      for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
      pv[0] = cap_v; pa[0] = cap_a;
      for (int s = 1; s <= 2; s++) begin
         freed[s] = 1'b0;
         if (st[s] == 2 && cyc >= done_cyc[s]) begin
            st[s] = 0; freed[s] = 1'b1; set_miss(s, 1'b0);
         end else if (st[s] == 2 && rand_drop && $urandom_range(0, 15) == 0) begin
            set_miss(s, 1'b0);
         end
      end
      if (w_acc) begin d_wr_req = 1'b0; w_acc = 1'b0; end
   endtask

   task automatic raise_miss(input int s, input logic [15:0] a);
      if (st[s] == 0 && !freed[s]) begin
         st[s] = 1;
         if (s == 1) begin i_miss = 1'b1; i_miss_addr = a; end
         else begin d_miss = 1'b1; d_miss_addr = a; end
      end
   endtask

   task automatic raise_wr(input logic [15:0] a, input logic [15:0] d);
      if (!d_wr_req) begin d_wr_req = 1'b1; d_wr_addr = a; d_wr_data = d; end
   endtask

   task automatic end_cycle();
      ev_t e;
      if (m_gr != 0 && cyc >= m_t0 + FILL_CYC + 1) m_gr = 0;
      m_busy   = (m_gr != 0);
      exp_busy = m_busy;
      exp_is   = i_miss | (m_busy && m_gr == 1);
      exp_ds   = d_miss | (m_busy && m_gr == 2) | (d_wr_req & (m_busy | d_miss));
      if (!m_busy) begin
         if (d_miss) grant(2, d_miss_addr);
         else if (d_wr_req) begin
            e.cyc = cyc; e.side = 0; e.a = d_wr_addr; e.d = d_wr_data;
            wrq.push_back(e); w_acc = 1'b1;
         end else if (i_miss) grant(1, i_miss_addr);
      end
      if (pv[3]) begin
         mem_data_valid = 1'b1; mem_data_out = memval(pa[3]);
      end else begin
         mem_data_out   = 16'($urandom);
         mem_data_valid = !m_busy && ($urandom_range(0, 3) == 0);
      end
      started = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin begin_cycle(); end_cycle(); end
   endtask

   task automatic pulse_reset();
      begin_cycle();
      rst_n = 1'b0; d_wr_req = 1'b1; mem_data_valid = 1'b0;
      m_gr = 0; w_acc = 1'b0;
      rdq.delete(); wrq.delete(); dq.delete(); tq.delete();
      for (int s = 0; s < 3; s++) begin st[s] = 0; n_fills[s] = 0; end
      for (int k = 0; k < 4; k++) pv[k] = 1'b0;
   endtask

   always @(negedge clk) begin
      cap_v = 1'b0; cap_a = '0;
      if (!rst_n) begin
         chk("reset_outputs", 64'({mem_addr, mem_data_in, mem_en, mem_wr, fill_data, fill_word,
             i_data_we, i_tag_we, d_data_we, d_tag_we, i_stall, d_stall, busy}), 64'h0);
      end else if (started) begin
         cap_v = mem_en & ~mem_wr; cap_a = mem_addr;
         chk("status_busy_istall_dstall", 64'({busy, i_stall, d_stall}), 64'({exp_busy, exp_is, exp_ds}));
         if (mem_en && mem_wr) begin
            if (wrq.size() == 0) fail_ev("unexpected_store", 64'({mem_addr, mem_data_in}));
            else begin
               mon_e = wrq.pop_front();
               chk("mem_store", {32'(cyc), mem_addr, mem_data_in}, {32'(mon_e.cyc), mon_e.a, mon_e.d});
            end
         end else if (mem_en) begin
            if (rdq.size() == 0) fail_ev("unexpected_read", 64'(mem_addr));
            else begin
               mon_e = rdq.pop_front();
               chk("mem_read", {32'(cyc), 16'h0, mem_addr}, {32'(mon_e.cyc), 16'h0, mon_e.a});
            end
         end
         if (i_data_we || d_data_we) begin
            mon_sd = (d_data_we ? 2 : 0) + (i_data_we ? 1 : 0);
            if (dq.size() == 0) fail_ev("unexpected_data_we", 64'({fill_word, fill_data}));
            else begin
               mon_e = dq.pop_front();
               chk("fill_data", {32'(cyc), 8'(mon_sd), 8'(fill_word), fill_data},
                   {32'(mon_e.cyc), 8'(mon_e.side), 8'(mon_e.a), mon_e.d});
            end
         end
         if (i_tag_we || d_tag_we) begin
            mon_sd = (d_tag_we ? 2 : 0) + (i_tag_we ? 1 : 0);
            if (tq.size() == 0) fail_ev("unexpected_tag_we", 64'(mon_sd));
            else begin
               mon_e = tq.pop_front();
               chk("tag_we", {32'(cyc), 32'(mon_sd)}, {32'(mon_e.cyc), 32'(mon_e.side)});
            end
         end
         while (rdq.size() > 0 && rdq[0].cyc < cyc) begin fail_ev("missing_read", 64'(rdq[0].a)); rdq.delete(0); end
         while (wrq.size() > 0 && wrq[0].cyc < cyc) begin fail_ev("missing_store", 64'(wrq[0].a)); wrq.delete(0); end
         while (dq.size() > 0 && dq[0].cyc < cyc) begin fail_ev("missing_data_we", 64'(dq[0].a)); dq.delete(0); end
         while (tq.size() > 0 && tq[0].cyc < cyc) begin fail_ev("missing_tag_we", 64'(tq[0].side)); tq.delete(0); end
      end
   end

   initial begin
      int n;
      for (int s = 0; s < 3; s++) begin st[s] = 0; done_cyc[s] = 0; n_fills[s] = 0; freed[s] = 1'b0; end
      for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pa[k] = '0; end
      repeat (2) @(negedge clk);

      begin_cycle(); raise_miss(1, 16'h0126); end_cycle(); idle(20);
      begin_cycle(); raise_miss(1, 16'h0510); raise_miss(2, 16'h4008); end_cycle(); idle(35);
      begin_cycle(); raise_wr(16'h2002, 16'hBEEF); end_cycle(); idle(3);
      begin_cycle(); raise_miss(1, 16'h0A1C); end_cycle(); idle(3);
      begin_cycle(); raise_wr(16'h2004, 16'h1234); end_cycle(); idle(20);
      begin_cycle(); raise_miss(2, 16'h4008); end_cycle(); idle(6);
      pulse_reset(); idle(2);
      begin_cycle(); raise_miss(2, 16'h4008); end_cycle(); idle(20);
      begin_cycle(); raise_miss(2, 16'hFFF6); end_cycle(); idle(16);

      rand_drop = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         begin_cycle();
         if ($urandom_range(0, 5) == 0) raise_miss(1, 16'($urandom));
         if ($urandom_range(0, 7) == 0) raise_miss(2, 16'($urandom));
         if ($urandom_range(0, 4) == 0) raise_wr(16'($urandom), 16'($urandom));
         end_cycle();
      end
      rand_drop = 1'b0;

      n = 0;
      while (n < 200 && !(st[1] == 0 && st[2] == 0 && !d_wr_req && m_gr == 0)) begin
         begin_cycle(); end_cycle(); n++;
      end
      if (n >= 200) fail_ev("drain_timeout", 64'(n));
      idle(4);
      chk("queues_drained", {16'(rdq.size()), 16'(wrq.size()), 16'(dq.size()), 16'(tq.size())}, 64'h0);
`ifdef MISS_ARB_PERF_CNT_EN
      chk("i_fill_cnt", 64'(i_fill_cnt), 64'(n_fills[1]));
      chk("d_fill_cnt", 64'(d_fill_cnt), 64'(n_fills[2]));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
